// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate-format and skid-state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_J     = 3'd4,
    FMT_U     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // fmt (3 bits) + illegal (1 bit) appended below the XLEN-wide immediate
  localparam int ENTRY_META_W = 4;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instruction word -> {imm, fmt, illegal}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline owns all flow control.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]                   in_inst,
  output logic [XLEN+ENTRY_META_W-1:0]  entry
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } imm_entry_t;

  imm_entry_t res;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_shift;
  logic       legal;

  assign opc      = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Sign-extend a 32-bit value from bit 31; XLEN-31 is always >= 1.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
    return {{(XLEN-6){1'b0}}, v};
  endfunction

  // Opcode-driven format selection; every illegal outcome collapses to NONE/0.
  always_comb begin
    res.imm     = '0;
    res.fmt     = FMT_NONE;
    res.illegal = 1'b0;
    legal       = 1'b1;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        res.fmt = FMT_I;
        res.imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        if (opc == OPC_OPIMM32 && XLEN == 32) begin
          legal = 1'b0;
        end else if (is_shift) begin
          res.fmt = FMT_SHAMT;
          if (opc == OPC_OPIMM && XLEN == 64) begin
            res.imm = zext6(in_inst[25:20]);
            legal   = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
          end else begin
            // RV32 shifts and the word-sized shifts carry a 5-bit shamt
            res.imm = zext6({1'b0, in_inst[24:20]});
            legal   = (in_inst[31:25] == 7'b0000000) || (in_inst[31:25] == 7'b0100000);
          end
          // Left shifts have no arithmetic variant
          if (f3 == 3'b001 && in_inst[30]) begin
            legal = 1'b0;
          end
        end else begin
          res.fmt = FMT_I;
          res.imm = sext32({{20{in_inst[31]}}, in_inst[31:20]});
        end
      end
      OPC_STORE: begin
        res.fmt = FMT_S;
        res.imm = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
      end
      OPC_BRANCH: begin
        res.fmt = FMT_B;
        res.imm = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                          in_inst[11:8], 1'b0});
      end
      OPC_JAL: begin
        res.fmt = FMT_J;
        res.imm = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                          in_inst[30:21], 1'b0});
      end
      OPC_LUI, OPC_AUIPC: begin
        res.fmt = FMT_U;
        res.imm = sext32({in_inst[31:12], 12'b0});
      end
      OPC_SYSTEM: begin
        if (f3[2]) begin
          res.fmt = FMT_ZIMM;
          res.imm = zext6({1'b0, in_inst[19:15]});
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      res.imm     = '0;
      res.fmt     = FMT_NONE;
      res.illegal = 1'b1;
    end
  end

  assign entry = res;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready on both sides and a 2-entry skid.
// Latency: 1 cycle from accept to out_valid when the output register is free or draining.
// Backpressure: registered in_ready drops once output reg and skid are both full.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } imm_entry_t;

  logic [XLEN+ENTRY_META_W-1:0] dec_vec;
  imm_entry_t  dec_ent;
  imm_entry_t  out_q;
  imm_entry_t  skid_q;
  skid_state_e state_q;
  skid_state_e state_d;
  logic        ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic        accept;
  logic        deliver;
  logic        load_out_in;
  logic        load_out_skid;
  logic        load_skid;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .in_inst (in_inst),
    .entry   (dec_vec)
  );

  assign dec_ent   = dec_vec;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && ready_q;
  assign deliver   = out_valid && out_ready;

  // Next-state and load-enable decode for the skid FSM; flush wins over accept.
  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !deliver) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (!accept && deliver) begin
          state_d = ST_EMPTY;
        end else if (accept && deliver) begin
          load_out_in = 1'b1;
        end
      end
      ST_TWO: begin
        if (deliver) begin
          state_d       = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d       = ST_EMPTY;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
    end
  end

  // State register and registered in_ready (free unless both slots will be full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_TWO);
    end
  end

  // Output and skid data registers; output only reloads when empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in) begin
        out_q <= dec_ent;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_ent;
      end
    end
  end

  // Saturating count of illegal entries handed downstream; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (deliver && out_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready    = ready_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 and RV64 instances share one stimulus stream.
// Reference: queue occupancy model plus arithmetic immediate decode.
// The RV64 instance uses a 3-bit counter so saturation is reachable.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = 32'h0;

  logic        rdy32, rdy64, v32, v64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [15:0] cnt32;
  logic [2:0]  cnt64;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q[$];
  int unsigned cnt32_m = 0;
  int unsigned cnt64_m = 0;
  logic last_acc;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64), .illegal_cnt(cnt64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value computed as a signed integer, then truncated to xlen.
  task automatic ref_dec(input logic [31:0] i, input int xlen,
                         output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    longint v = 0;
    bit ok = 1;
    int sh;
    logic [11:0] fld;
    fmt = 3'd0;
    fld = i[31:20];
    case (i[6:0])
      7'h03, 7'h67: begin fmt = 3'd1; v = $signed(i[31:20]); end
      7'h13, 7'h1B: begin
        if (i[6:0] == 7'h1B && xlen == 32) ok = 0;
        else if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          fmt = 3'd6;
          sh = (i[6:0] == 7'h13 && xlen == 64) ? 6 : 5;
          if ((fld >> sh) != 0 && (fld >> sh) != (12'd1 << (10 - sh))) ok = 0;
          if (i[14:12] == 3'd1 && i[30]) ok = 0;
          v = longint'(fld) & ((64'd1 << sh) - 1);
        end else begin
          fmt = 3'd1; v = $signed(i[31:20]);
        end
      end
      7'h23: begin fmt = 3'd2; v = $signed({i[31:25], i[11:7]}); end
      7'h63: begin fmt = 3'd3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
      7'h6F: begin fmt = 3'd4; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
      7'h37, 7'h17: begin fmt = 3'd5; v = $signed({i[31:12], 12'h000}); end
      7'h73: begin
        if (i[14]) begin fmt = 3'd7; v = longint'(i[19:15]); end
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin fmt = 3'd0; v = 0; end
    ill = !ok;
    imm = (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
  endtask

  // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
  task automatic cycle();
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill, acc, dlv;
    @(negedge clk);
    chk("in_ready32", rdy32, q.size() < 2);
    chk("in_ready64", rdy64, q.size() < 2);
    chk("out_valid32", v32, q.size() > 0);
    chk("out_valid64", v64, q.size() > 0);
    if (q.size() > 0) begin
      ref_dec(q[0], 32, e_imm, e_fmt, e_ill);
      chk("imm32", imm32, e_imm);
      chk("fmt32", fmt32, e_fmt);
      chk("ill32", ill32, e_ill);
      ref_dec(q[0], 64, e_imm, e_fmt, e_ill);
      chk("imm64", imm64, e_imm);
      chk("fmt64", fmt64, e_fmt);
      chk("ill64", ill64, e_ill);
    end
    chk("cnt32", cnt32, cnt32_m);
    chk("cnt64", cnt64, cnt64_m);
    acc = in_valid && (q.size() < 2);
    dlv = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (dlv) begin
      ref_dec(q[0], 32, e_imm, e_fmt, e_ill);
      if (e_ill && cnt32_m < 65535) cnt32_m++;
      ref_dec(q[0], 64, e_imm, e_fmt, e_ill);
      if (e_ill && cnt64_m < 7) cnt64_m++;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (acc) q.push_back(in_inst);
    last_acc = acc && !flush;
    #1;
  endtask

  task automatic push(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_acc) break;
    end
    chk("push_timeout", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [12] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F,
                              7'h67, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h33};
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opcs[$urandom_range(0, 11)];
    if ((r[6:0] == 7'h13 || r[6:0] == 7'h1B) && ($urandom_range(0, 1) == 1)) begin
      r[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
      r[31:26] = ($urandom_range(0, 1) == 1) ? 6'b010000 : 6'b000000;
      if ($urandom_range(0, 1) == 1) r[25] = 1'b0;
    end
    return r;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", v32, 1'b0);
    chk("rst_imm", imm64, 64'h0);
    chk("rst_fmt", fmt32, 3'd0);
    chk("rst_illegal", ill32, 1'b0);
    chk("rst_cnt", cnt32, 16'h0);
    chk("rst_in_ready", rdy32, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Two illegal encodings on RV32 (0x1B is addiw on RV64, legal there)
    push(32'h0000001B);
    push(32'hFFFFFFFF);
    idle(2);
    chk("cnt32_two_illegal", cnt32, 16'd2);
    chk("cnt64_one_illegal", cnt64, 3'd1);

    // addi x1,x0,-1: one-cycle latency
    push(32'hFFF00093);
    chk("addi_valid", v32, 1'b1);
    chk("addi_imm32", imm32, 32'hFFFFFFFF);
    chk("addi_fmt", fmt32, 3'd1);
    chk("addi_ill", ill32, 1'b0);
    idle(1);

    // jal with imm[20]=1, slli by 63
    push(32'h8000006F);
    chk("jal_imm64", imm64, 64'hFFFFFFFFFFF00000);
    chk("jal_fmt64", fmt64, 3'd4);
    idle(1);
    push(32'h03F01093);
    chk("slli63_imm64", imm64, 64'd63);
    chk("slli63_fmt64", fmt64, 3'd6);
    chk("slli63_ill64", ill64, 1'b0);
    chk("slli63_ill32", ill32, 1'b1);
    idle(1);

    // Saturate the 3-bit counter of the RV64 instance
    for (int k = 0; k < 8; k++) push(32'hFFFFFFFF);
    idle(3);
    chk("cnt64_saturated", cnt64, 3'd7);

    // Backpressure: three entries against a stalled consumer
    out_ready = 1'b0;
    push(32'h00100093);
    push(32'h00200093);
    chk("bp_in_ready_low", rdy32, 1'b0);
    in_valid = 1'b1;
    in_inst  = 32'h00300093;
    idle(3);
    out_ready = 1'b1;
    push(32'h00300093);
    idle(4);
    chk("bp_drained", v32, 1'b0);

    // Flush while full with a pending request
    out_ready = 1'b0;
    push(32'h00400093);
    push(32'h00500093);
    in_valid = 1'b1;
    in_inst  = 32'h00700093;
    flush    = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", v32, 1'b0);
    chk("flush_in_ready", rdy32, 1'b1);
    out_ready = 1'b1;
    idle(3);

    // Flush coincident with delivery of an illegal entry (still counted) and an accept
    out_ready = 1'b0;
    push(32'hFFFFFFFF);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h00900093;
    flush     = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    idle(2);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_inst   = rand_inst();
      cycle();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Asynchronous reset mid-cycle with a buffered entry
    out_ready = 1'b0;
    push(32'hFFFFFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid32", v32, 1'b0);
    chk("arst_out_valid64", v64, 1'b0);
    chk("arst_cnt32", cnt32, 16'h0);
    chk("arst_cnt64", cnt64, 3'h0);
    q.delete();
    cnt32_m = 0;
    cnt64_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("arst_in_ready", rdy32, 1'b1);
    out_ready = 1'b1;
    push(32'h0000A0B7);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
